led_pattern_ctrl: RTL and testbench

Sequencer for the 4-bit board LED bank. A step prescaler paces a small pattern state machine: running light, blink, binary count or off. A valid/ready mode-request port lets a key handler or host change modes. Sits between the system clock/reset and `pio_led`, and replaces the free-running LED driver as the single owner of the LED pins.

---
 rtl/led_pattern_ctrl.sv | 133 +++++++++++++
 tb/tb_led_pattern_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: prescaled pattern FSM with valid/ready mode requests.
// Optional PWM dimming of the LED outputs is enabled by defining LED_PWM_EN.
module led_pattern_ctrl #(
  parameter int unsigned STEP_CYCLES = 12_500_000,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode_valid,
  input  logic [1:0]          mode,
  output logic                mode_ready,
  input  logic                pause,
  input  logic [PWM_BITS-1:0] duty,
  output logic                step_tick,
  output logic [3:0]          pio_led
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeRun   = 2'b01,
    ModeBlink = 2'b10,
    ModeCount = 2'b11
  } mode_e;

  typedef enum logic {StActive, StPending} state_e;

  logic [CntW-1:0] cnt_q, cnt_d;
  state_e          state_q, state_d;
  mode_e           cur_q, cur_d;
  mode_e           pend_q, pend_d;
  logic [3:0]      pat_q, pat_d;

  function automatic logic [3:0] init_pattern(input mode_e m);
    logic [3:0] p;
    unique case (m)
      ModeOff:   p = 4'b0000;
      ModeRun:   p = 4'b0001;
      ModeBlink: p = 4'b1111;
      ModeCount: p = 4'b0000;
      default:   p = 4'b0000;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] next_pattern(input mode_e m, input logic [3:0] p);
    logic [3:0] n;
    unique case (m)
      ModeOff:   n = 4'b0000;
      ModeRun:   n = {p[2:0], p[3]};
      ModeBlink: n = ~p;
      ModeCount: n = p + 4'd1;
      default:   n = 4'b0000;
    endcase
    return n;
  endfunction

  // Prescaler freezes entirely while paused, so no tick can slip through.
  always_comb begin
    cnt_d = cnt_q;
    if (!pause) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  assign step_tick = (cnt_q == CntLast) && !pause;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pat_d      = pat_q;
    mode_ready = 1'b0;
    unique case (state_q)
      StActive: begin
        mode_ready = 1'b1;
        // A tick in the acceptance cycle still belongs to the old mode.
        if (step_tick) begin
          pat_d = next_pattern(cur_q, pat_q);
        end
        if (mode_valid) begin
          pend_d  = mode_e'(mode);
          state_d = StPending;
        end
      end
      StPending: begin
        if (step_tick) begin
          pat_d   = init_pattern(pend_q);
          cur_d   = pend_q;
          state_d = StActive;
        end
      end
      default: state_d = StActive;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= StActive;
      cur_q   <= ModeRun;
      pend_q  <= ModeOff;
      pat_q   <= 4'b0001;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      pat_q   <= pat_d;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign pio_led = pat_q & {4{duty > pwm_cnt_q}};
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign pio_led     = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl (STEP_CYCLES small).
module tb_led_pattern_ctrl;

`ifdef LED_PWM_EN
  localparam int unsigned Steps = 64;
`else
  localparam int unsigned Steps = 4;
`endif

  logic       clk;
  logic       rst_n;
  logic       mode_valid;
  logic [1:0] mode;
  logic       mode_ready;
  logic       pause;
  logic [3:0] duty;
  logic       step_tick;
  logic [3:0] pio_led;

  int vectors;
  int miscompares;

  led_pattern_ctrl #(
    .STEP_CYCLES(Steps),
    .PWM_BITS   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_valid(mode_valid),
    .mode      (mode),
    .mode_ready(mode_ready),
    .pause     (pause),
    .duty      (duty),
    .step_tick (step_tick),
    .pio_led   (pio_led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to the next sample where step_tick is high, bounded.
  task automatic wait_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 2 * Steps + 4; i++) begin
      @(negedge clk);
      if (step_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    mode_valid = 1'b0;
    mode       = 2'b00;
    pause      = 1'b0;
    duty       = 4'd4;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (pio_led !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_pio got %b want 0001", pio_led);
    end
    vectors++;
    if (mode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 1", mode_ready);
    end
    vectors++;
    if (step_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tick got %b want 0", step_tick);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run_light();
    logic [3:0] exp_seq [0:4];
    int         idx;
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    idx = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      vectors++;
      if (step_tick !== ((c % 4) == 3)) begin
        miscompares++;
        $display("FAIL run_tick c=%0d got %b want %b", c, step_tick, (c % 4) == 3);
      end
      vectors++;
      if (pio_led !== exp_seq[idx]) begin
        miscompares++;
        $display("FAIL run_pio c=%0d got %b want %b", c, pio_led, exp_seq[idx]);
      end
      if ((c % 4) == 3) idx++;
    end
  endtask

  task automatic test_blink();
    bit found;
    wait_tick(found);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL blink_align got no tick want tick");
    end
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b0010 || mode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL blink_pre got pio=%b rdy=%b want pio=0010 rdy=1", pio_led, mode_ready);
    end
    mode_valid = 1'b1;
    mode       = 2'b10;
    @(negedge clk);
    mode_valid = 1'b0;
    vectors++;
    if (mode_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_ready_drop got %b want 0", mode_ready);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (step_tick !== 1'b1 || pio_led !== 4'b0010 || mode_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_switch_tick got tick=%b pio=%b rdy=%b want 1 0010 0",
               step_tick, pio_led, mode_ready);
    end
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b1111 || mode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL blink_first got pio=%b rdy=%b want 1111 1", pio_led, mode_ready);
    end
    wait_tick(found);
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b0000) begin
      miscompares++;
      $display("FAIL blink_second got %b want 0000", pio_led);
    end
    wait_tick(found);
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b1111) begin
      miscompares++;
      $display("FAIL blink_third got %b want 1111", pio_led);
    end
  endtask

  task automatic test_count_in_tick();
    bit         found;
    logic [3:0] want;
    wait_tick(found);
    vectors++;
    if (!found || pio_led !== 4'b1111) begin
      miscompares++;
      $display("FAIL count_align got found=%b pio=%b want 1 1111", found, pio_led);
    end
    mode_valid = 1'b1;
    mode       = 2'b11;
    @(negedge clk);
    mode_valid = 1'b0;
    vectors++;
    if (mode_ready !== 1'b0 || pio_led !== 4'b0000) begin
      miscompares++;
      $display("FAIL count_old_advance got rdy=%b pio=%b want 0 0000", mode_ready, pio_led);
    end
    wait_tick(found);
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b0000 || mode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL count_init got pio=%b rdy=%b want 0000 1", pio_led, mode_ready);
    end
    for (int k = 1; k <= 16; k++) begin
      wait_tick(found);
      @(negedge clk);
      want = 4'(k);
      vectors++;
      if (pio_led !== want) begin
        miscompares++;
        $display("FAIL count_step k=%0d got %b want %b", k, pio_led, want);
      end
    end
  endtask

  task automatic test_pause_pending();
    mode_valid = 1'b1;
    mode       = 2'b01;
    @(negedge clk);
    mode_valid = 1'b0;
    vectors++;
    if (mode_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_accept got rdy=%b want 0", mode_ready);
    end
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    #1;
    vectors++;
    if (step_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_mask got tick=%b want 0", step_tick);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (step_tick !== 1'b0 || mode_ready !== 1'b0 || pio_led !== 4'b0000) begin
        miscompares++;
        $display("FAIL pause_hold i=%0d got tick=%b rdy=%b pio=%b want 0 0 0000",
                 i, step_tick, mode_ready, pio_led);
      end
    end
    pause = 1'b0;
    #1;
    vectors++;
    if (step_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_resume_tick got %b want 1", step_tick);
    end
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b0001 || mode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_switch got pio=%b rdy=%b want 0001 1", pio_led, mode_ready);
    end
  endtask

  task automatic test_reset_pending();
    bit found;
    wait_tick(found);
    @(negedge clk);
    vectors++;
    if (!found || pio_led !== 4'b0010) begin
      miscompares++;
      $display("FAIL rstp_pre got found=%b pio=%b want 1 0010", found, pio_led);
    end
    mode_valid = 1'b1;
    mode       = 2'b00;
    @(negedge clk);
    mode_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pio_led !== 4'b0001 || mode_ready !== 1'b1 || step_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL rstp_async got pio=%b rdy=%b tick=%b want 0001 1 0",
               pio_led, mode_ready, step_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (step_tick !== (c == 3)) begin
        miscompares++;
        $display("FAIL rstp_first_tick c=%0d got %b want %b", c, step_tick, c == 3);
      end
    end
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b0010 || mode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstp_resume got pio=%b rdy=%b want 0010 1", pio_led, mode_ready);
    end
  endtask

  task automatic test_no_overwrite();
    mode_valid = 1'b1;
    mode       = 2'b10;
    @(negedge clk);
    vectors++;
    if (mode_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL novw_accept got rdy=%b want 0", mode_ready);
    end
    mode = 2'b00;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (step_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL novw_tick got %b want 1", step_tick);
    end
    mode_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (pio_led !== 4'b1111 || mode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL novw_switch got pio=%b rdy=%b want 1111 1", pio_led, mode_ready);
    end
  endtask

  task automatic test_pwm();
    int ones;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pio_led[0] === 1'b1) ones++;
      vectors++;
      if (pio_led[3:1] !== 3'b000) begin
        miscompares++;
        $display("FAIL pwm_upper i=%0d got %b want 000", i, pio_led[3:1]);
      end
    end
    vectors++;
    if (ones != 4) begin
      miscompares++;
      $display("FAIL pwm_duty4 got %0d on-cycles want 4", ones);
    end
    duty = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if (pio_led !== 4'b0000) begin
        miscompares++;
        $display("FAIL pwm_duty0 i=%0d got %b want 0000", i, pio_led);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
`ifdef LED_PWM_EN
    test_pwm();
`else
    test_run_light();
    test_blink();
    test_count_in_tick();
    test_pause_pending();
    test_reset_pending();
    test_no_overwrite();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
